// File: rtl/register_file_pkg.sv
// Shared processor constants and helpers used by the pipeline stages and the register file.
// Pure declarations, no state.
package register_file_pkg;

    localparam int REG_COUNT  = 8;
    localparam int REG_ADDR_W = 3;
    localparam int DATA_W     = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;
    typedef logic [REG_COUNT-1:0]  reg_mask_t;

    // One-hot decode of a register address; register 0 decodes to an empty mask.
    function automatic reg_mask_t addr_onehot(input reg_addr_t addr);
        reg_mask_t mask;
        mask       = '0;
        mask[addr] = (addr != '0);
        return mask;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: busy bits, set/clear on the edge, combinational RAW/WAW stall.
// Stall is zero-latency; a same-cycle write-back to a busy register clears its hazard.
module reg_scoreboard
    import register_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regWriteOut,
    input  logic [REG_ADDR_W-1:0] loadAddr,
    input  logic [REG_ADDR_W-1:0] rs1Addr,
    input  logic [REG_ADDR_W-1:0] rs2Addr,
    input  logic                  issueValid,
    input  logic                  issueWrites,
    input  logic [REG_ADDR_W-1:0] issueRd,
    output logic                  stall,
    output logic [REG_COUNT-1:0]  busyMask
);

    reg_mask_t busy_q;
    reg_mask_t busy_d;
    reg_mask_t wb_clear;
    reg_mask_t busy_eff;
    reg_mask_t set_vec;
    logic      haz_rs1;
    logic      haz_rs2;
    logic      haz_waw;
    logic      issue_accept;

    always_comb begin
        wb_clear     = regWriteOut ? addr_onehot(loadAddr) : '0;
        // Hazards are judged against the scoreboard as it will look after this write-back.
        busy_eff     = busy_q & ~wb_clear;
        haz_rs1      = (rs1Addr != '0) && busy_eff[rs1Addr];
        haz_rs2      = (rs2Addr != '0) && busy_eff[rs2Addr];
        haz_waw      = issueWrites && (issueRd != '0) && busy_eff[issueRd];
        stall        = issueValid && (haz_rs1 || haz_rs2 || haz_waw);
        issue_accept = issueValid && !stall;
        set_vec      = (issue_accept && issueWrites) ? addr_onehot(issueRd) : '0;
        // Set wins over a same-cycle clear of the same register.
        busy_d       = busy_eff | set_vec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busyMask = busy_q;

endmodule

// File: rtl/register_file.sv
// 8x16 register file with write-back bypass and an issue scoreboard; reads are zero-latency.
// Decode is held via stall while a source or destination has a pending write.
module register_file
    import register_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regWriteOut,
    input  logic [REG_ADDR_W-1:0] loadAddr,
    input  logic [DATA_W-1:0]     loadData,
    input  logic [REG_ADDR_W-1:0] rs1Addr,
    input  logic [REG_ADDR_W-1:0] rs2Addr,
    output logic [DATA_W-1:0]     rs1Data,
    output logic [DATA_W-1:0]     rs2Data,
    input  logic                  issueValid,
    input  logic                  issueWrites,
    input  logic [REG_ADDR_W-1:0] issueRd,
    output logic                  stall,
    output logic [REG_COUNT-1:0]  busyMask
);

    reg_data_t regs_q [REG_COUNT];
    reg_data_t regs_d [REG_COUNT];
    logic      wr_en;

    assign wr_en = regWriteOut && (loadAddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[loadAddr] = loadData;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Same-cycle write-back is forwarded so decode sees the value before it lands.
    always_comb begin
        rs1Data = '0;
        rs2Data = '0;
        if (rs1Addr != '0) begin
            rs1Data = (wr_en && (loadAddr == rs1Addr)) ? loadData : regs_q[rs1Addr];
        end
        if (rs2Addr != '0) begin
            rs2Data = (wr_en && (loadAddr == rs2Addr)) ? loadData : regs_q[rs2Addr];
        end
    end

    reg_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .regWriteOut (regWriteOut),
        .loadAddr    (loadAddr),
        .rs1Addr     (rs1Addr),
        .rs2Addr     (rs2Addr),
        .issueValid  (issueValid),
        .issueWrites (issueWrites),
        .issueRd     (issueRd),
        .stall       (stall),
        .busyMask    (busyMask)
    );

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single system clock; all state updates occur on its rising edge.
REQ-002 SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL provide port regWriteOut, input, 1 bit: write-back write enable, driven by the write stage.
REQ-004 SHALL provide port loadAddr, input, 3 bits: write-back destination register.
REQ-005 SHALL provide port loadData, input, 16 bits: write-back data.
REQ-006 SHALL provide ports rs1Addr and rs2Addr, input, 3 bits each: decode-stage read addresses.
REQ-007 SHALL provide ports rs1Data and rs2Data, output, 16 bits each: read data.
REQ-008 SHALL provide port issueValid, input, 1 bit: decode is presenting an instruction for issue.
REQ-009 SHALL provide port issueWrites, input, 1 bit: the presented instruction writes a destination register.
REQ-010 SHALL provide port issueRd, input, 3 bits: destination of the presented instruction.
REQ-011 SHALL provide port stall, output, 1 bit: decode must hold the presented instruction.
REQ-012 SHALL provide port busyMask, output, 8 bits: scoreboard state, where bit n means register n has a pending write.

Function
REQ-013 SHALL hold 8 registers of 16 bits; register 0 SHALL always read 0x0000, and writes to it SHALL be ignored.
REQ-014 SHALL write loadData into register loadAddr on the rising clk edge when regWriteOut=1 and loadAddr!=0.
REQ-015 SHALL drive rsXData combinationally with zero-cycle latency: 0 if rsXAddr=0; otherwise loadData if regWriteOut=1 and loadAddr=rsXAddr (same-cycle bypass); otherwise the stored value.
REQ-016 SHALL define wbClear[n] = regWriteOut and (loadAddr=n) and n!=0.
REQ-017 SHALL define hazard on read port X as busy[rsXAddr] and not wbClear[rsXAddr]; rsXAddr=0 SHALL never hazard.
REQ-018 SHALL define hazard on the destination (WAW) as issueWrites and busy[issueRd] and not wbClear[issueRd]; issueRd=0 SHALL never hazard.
REQ-019 SHALL assert stall combinationally when issueValid=1 and any hazard in REQ-017/REQ-018 is true; stall SHALL be 0 when issueValid=0.
REQ-020 SHALL treat an issue as accepted when issueValid=1 and stall=0.
REQ-021 SHALL set busy[issueRd] on the next edge when an accepted issue has issueWrites=1 and issueRd!=0.
REQ-022 SHALL clear busy[n] on the edge where wbClear[n]=1.
REQ-023 SHALL apply set-wins when set and clear target the same register in one cycle: busy stays 1.
REQ-024 SHALL treat a write-back to a non-busy register as a plain write; it SHALL NOT raise an error or change any other busy bit.
REQ-025 SHALL drive busyMask as the registered busy vector, with bit 0 always 0.

Reset
REQ-026 SHALL, while reset=1, asynchronously clear all registers and busy bits to 0, regardless of clk.
REQ-027 SHALL, during reset: rs1Data and rs2Data show the stored 0 (the bypass still applies combinationally), busyMask=0x00, and stall follows REQ-019 against the cleared scoreboard (0 for a read/WAW check).
REQ-028 SHALL NOT accept writes or issues on an edge where reset=1; a pending write-back in flight at reset SHALL be lost.

Structure
REQ-029 SHALL take the constants REG_COUNT=8, REG_ADDR_W=3 and DATA_W=16 from the shared processor package used by the pipeline stages.
REQ-030 SHALL be split into one sub-module, reg_scoreboard, holding the busy bits, the set/clear logic and the hazard/stall generation; the storage array and bypass mux SHALL stay in register_file.

Verification
REQ-031 Reset: hold reset=1 with regWriteOut=1, loadAddr=5, loadData=0xAAAA for 2 edges -> all reads 0x0000 when regWriteOut=0, busyMask=0x00; release reset -> next edge writes r5=0xAAAA.
REQ-032 Write/read and bypass: write r3=0x1234, then read rs1Addr=3 -> 0x1234; in the same cycle drive regWriteOut=1, loadAddr=3, loadData=0xBEEF -> rs1Data=0xBEEF before the edge.
REQ-033 Register 0: regWriteOut=1, loadAddr=0, loadData=0xFFFF -> rs1Addr=0 reads 0x0000 both before and after the edge.
REQ-034 RAW stall: issue with issueWrites=1, issueRd=2 -> busyMask=0x04; next issue with rs2Addr=2 -> stall=1; write-back to r2 with loadData=0x0042 in the same cycle -> stall=0 and rs2Data=0x0042.
REQ-035 WAW and set-wins: r4 busy; issue with issueRd=4 and no write-back -> stall=1; with a write-back to r4 in the same cycle -> stall=0, the issue is accepted, and busyMask bit 4 remains 1 after the edge.
REQ-036 Reset mid-operation: busyMask=0x26, assert reset asynchronously between edges -> busyMask=0x00 immediately and stall=0 for issueRd=5.
